axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
- Single-port AXI3-subset responder (slave) backed by an internal word-addressed memory.
- Sits on the far end of the core's AXI master bus, in place of the SoC crossbar and RAM, for core-level simulation and bring-up.
- Serves one read burst and one write burst concurrently: independent read and write FSMs, INCR bursts only, 32-bit beats.

Parameters:
ADDR_W, 12, word-address width; memory depth is 2^ADDR_W 32-bit words.
READ_LAT, 2, extra wait cycles between the AR handshake and the first read beat.
WRITE_LAT, 1, wait cycles between the last W handshake and bvalid.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  synchronous, active-high reset.
arid  in  4  read transaction ID.
araddr  in  32  read byte address; bits [1:0] ignored.
arlen  in  4  read burst length minus 1 (1..16 beats).
arvalid  in  1  read address valid.
arready  out  1  read address accepted.
rid  out  4  ID echoed from arid.
rdata  out  32  read beat data.
rresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
rlast  out  1  final beat of the read burst.
rvalid  out  1  read beat valid.
rready  in  1  master accepts the read beat.
awid  in  4  write transaction ID.
awaddr  in  32  write byte address; bits [1:0] ignored.
awlen  in  4  write burst length minus 1.
awvalid  in  1  write address valid.
awready  out  1  write address accepted.
wdata  in  32  write beat data.
wstrb  in  4  byte enables; bit i covers wdata[8i+7:8i].
wlast  in  1  master's last-beat marker; checked, not used for counting.
wvalid  in  1  write beat valid.
wready  out  1  write beat accepted.
bid  out  4  ID echoed from awid.
bresp  out  2  2'b00 OKAY, 2'b10 SLVERR.
bvalid  out  1  write response valid.
bready  in  1  master accepts the write response.

Behaviour:
- **Reset (reset=1 at a clk edge):**
  - Next-cycle outputs: arready=1, awready=1, rvalid=0, rlast=0, wready=0, bvalid=0, rid=bid=0, rresp=bresp=0, rdata=0.
  - Both FSMs return to IDLE. Memory contents are not cleared.
  - Reset mid-burst aborts the burst; no further beats or responses are issued for it.
- **Read FSM (R_IDLE -> R_WAIT -> R_DATA):**
  - R_IDLE: arready=1. On arvalid&arready, latch id, word address araddr[ADDR_W+1:2], arlen, and err = (araddr[31:ADDR_W+2] != 0). Beat counter = 0. arready=0 from the next cycle.
  - R_WAIT: counts READ_LAT cycles, then moves to R_DATA. READ_LAT=0 goes directly to R_DATA.
  - Timing: first rvalid rises exactly READ_LAT+1 cycles after the AR handshake edge.
  - R_DATA: rvalid=1; rdata = err ? 0 : mem[addr]; rresp = err ? 2'b10 : 2'b00; rlast = (beat == len).
  - Stall: while rready=0, all R outputs hold stable.
  - On rvalid&rready: addr+1 (wraps modulo 2^ADDR_W), beat+1. On the last beat go to R_IDLE, with rvalid=0 and arready=1 the next cycle.
  - Back-to-back reads are possible with one idle cycle between bursts.
- **Write FSM (W_IDLE -> W_DATA -> W_WAIT -> W_RESP):**
  - W_IDLE: awready=1. The handshake latches id, address, len and err (same rule as read).
  - W_DATA: wready=1. Each wvalid&wready writes the wstrb-enabled bytes of wdata into mem[addr] (suppressed if err), then addr+1 and beat+1.
  - Protocol error flag: set if wlast=1 on a non-final beat, or wlast=0 on beat==len.
  - After beat==len is accepted: wready=0, then W_WAIT for WRITE_LAT cycles (0 = skip), then W_RESP.
  - W_RESP: bvalid=1, bid=id, bresp = (err | protocol error) ? 2'b10 : 2'b00. Hold until bready, then W_IDLE with awready=1 the next cycle.
- **Concurrency:**
  - The read and write FSMs run independently; AR and AW may be accepted in the same cycle.
  - A read beat and a write beat to the same word in the same cycle: the read returns the pre-write data. The write is visible from the next cycle.
- **Unsupported fields:** burst/size/lock/cache/prot are not ports. All bursts are treated as INCR with 4-byte beats, and wid is not checked.

Test Plan:
1. Single write, awid=3, awaddr=0x10, awlen=0, wdata=0xDEADBEEF, wstrb=4'hF -> bvalid 2 cycles after the W handshake, bid=3, bresp=0. Then read arid=5, araddr=0x10 -> rvalid 3 cycles after the AR handshake, rdata=0xDEADBEEF, rid=5, rlast=1, rresp=0.
2. 4-beat write at 0x100 with data 1,2,3,4, then arlen=3 read with rready pattern 1,0,0,1,1,0,1 -> beats 1,2,3,4 in order, held stable during stalls, rlast only with data 4.
3. Write 0xFFFFFFFF to 0x20, then wstrb=4'b0101 with wdata=0x11223344 -> read of 0x20 returns 0xFF22FF44.
4. ADDR_W=12: read araddr=0x4000, arlen=1 -> 2 beats with rdata=0 and rresp=2'b10. Write awaddr=0x4000 -> bresp=2'b10, and a read of 0x0000 is unchanged.
5. awlen=2 with wlast=1 on beat 0 -> 3 beats still accepted and written, bresp=2'b10.
6. reset=1 during beat 2 of a 4-beat read -> next cycle rvalid=0, rlast=0, arready=1. A fresh read after that completes normally.

Source files
------------

// File: rtl/axi_sram_slave_if.sv
// AXI3-subset read/write channel bundle between a core master and the SRAM responder.
// INCR-only, 32-bit beats; burst/size/lock/cache/prot and wid are deliberately absent.
interface axi_sram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic        arvalid;
    logic        arready;

    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;

    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport slave (
        input  arid, araddr, arlen, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

    modport master (
        output arid, araddr, arlen, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI3-subset SRAM responder: independent read and write burst engines over one
// word-addressed memory. Out-of-range addresses return SLVERR and never touch memory.
module axi_sram_slave #(
    parameter int unsigned ADDR_W    = 12,
    parameter int unsigned READ_LAT  = 2,
    parameter int unsigned WRITE_LAT = 1
) (
    input logic              clk,
    input logic              reset,
    axi_sram_slave_if.slave  bus
);

    localparam logic [7:0] RLatLast = 8'(READ_LAT - 1);
    localparam logic [7:0] WLatLast = 8'(WRITE_LAT - 1);

    typedef enum logic [1:0] {RIdle, RWait, RData} rstate_e;
    typedef enum logic [1:0] {WIdle, WData, WWait, WResp} wstate_e;

    logic [31:0] mem [2**ADDR_W];

    // ---------------- read engine ----------------
    rstate_e           rstate_q;
    logic [ADDR_W-1:0] raddr_q;
    logic [3:0]        rlen_q;
    logic [3:0]        rbeat_q;
    logic              rerr_q;
    logic [7:0]        rcnt_q;
    logic              arready_q;
    logic              rvalid_q;
    logic              rlast_q;
    logic [3:0]        rid_q;
    logic [1:0]        rresp_q;
    logic              ar_err;

    assign ar_err = (bus.araddr >> (ADDR_W + 2)) != '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rstate_q  <= RIdle;
            raddr_q   <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rerr_q    <= 1'b0;
            rcnt_q    <= '0;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rid_q     <= '0;
            rresp_q   <= '0;
        end else begin
            unique case (rstate_q)
                RIdle: begin
                    if (bus.arvalid && arready_q) begin
                        rid_q     <= bus.arid;
                        raddr_q   <= bus.araddr[ADDR_W+1:2];
                        rlen_q    <= bus.arlen;
                        rbeat_q   <= '0;
                        rerr_q    <= ar_err;
                        rresp_q   <= ar_err ? 2'b10 : 2'b00;
                        rcnt_q    <= '0;
                        arready_q <= 1'b0;
                        if (READ_LAT == 0) begin
                            rstate_q <= RData;
                            rvalid_q <= 1'b1;
                            rlast_q  <= (bus.arlen == 4'd0);
                        end else begin
                            rstate_q <= RWait;
                        end
                    end
                end
                RWait: begin
                    if (rcnt_q == RLatLast) begin
                        rstate_q <= RData;
                        rvalid_q <= 1'b1;
                        rlast_q  <= (rlen_q == 4'd0);
                    end else begin
                        rcnt_q <= rcnt_q + 8'd1;
                    end
                end
                RData: begin
                    if (bus.rready) begin
                        if (rlast_q) begin
                            rstate_q  <= RIdle;
                            rvalid_q  <= 1'b0;
                            rlast_q   <= 1'b0;
                            arready_q <= 1'b1;
                        end else begin
                            raddr_q <= raddr_q + 1'b1;
                            rbeat_q <= rbeat_q + 4'd1;
                            rlast_q <= ((rbeat_q + 4'd1) == rlen_q);
                        end
                    end
                end
                default: rstate_q <= RIdle;
            endcase
        end
    end

    // Combinational array read: a same-cycle write lands after this beat is sampled.
    assign bus.rdata   = (rvalid_q && !rerr_q) ? mem[raddr_q] : 32'h0;
    assign bus.arready = arready_q;
    assign bus.rvalid  = rvalid_q;
    assign bus.rlast   = rlast_q;
    assign bus.rid     = rid_q;
    assign bus.rresp   = rresp_q;

    // ---------------- write engine ----------------
    wstate_e           wstate_q;
    logic [ADDR_W-1:0] waddr_q;
    logic [3:0]        wlen_q;
    logic [3:0]        wbeat_q;
    logic              werr_q;
    logic              perr_q;
    logic [7:0]        wcnt_q;
    logic              awready_q;
    logic              wready_q;
    logic              bvalid_q;
    logic [3:0]        bid_q;
    logic [1:0]        bresp_q;
    logic              aw_err;
    logic              w_fire;
    logic              w_last_beat;
    logic              w_proto_bad;

    assign aw_err      = (bus.awaddr >> (ADDR_W + 2)) != '0;
    assign w_fire      = wready_q && bus.wvalid;
    assign w_last_beat = (wbeat_q == wlen_q);
    assign w_proto_bad = (bus.wlast != w_last_beat);

    always_ff @(posedge clk) begin
        if (reset) begin
            wstate_q  <= WIdle;
            waddr_q   <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
            perr_q    <= 1'b0;
            wcnt_q    <= '0;
            awready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
            bresp_q   <= '0;
        end else begin
            unique case (wstate_q)
                WIdle: begin
                    if (bus.awvalid && awready_q) begin
                        bid_q     <= bus.awid;
                        waddr_q   <= bus.awaddr[ADDR_W+1:2];
                        wlen_q    <= bus.awlen;
                        wbeat_q   <= '0;
                        werr_q    <= aw_err;
                        perr_q    <= 1'b0;
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        wstate_q  <= WData;
                    end
                end
                WData: begin
                    if (w_fire) begin
                        perr_q <= perr_q | w_proto_bad;
                        if (w_last_beat) begin
                            wready_q <= 1'b0;
                            wcnt_q   <= '0;
                            if (WRITE_LAT == 0) begin
                                wstate_q <= WResp;
                                bvalid_q <= 1'b1;
                                bresp_q  <= (werr_q || perr_q || w_proto_bad) ? 2'b10 : 2'b00;
                            end else begin
                                wstate_q <= WWait;
                            end
                        end else begin
                            waddr_q <= waddr_q + 1'b1;
                            wbeat_q <= wbeat_q + 4'd1;
                        end
                    end
                end
                WWait: begin
                    if (wcnt_q == WLatLast) begin
                        wstate_q <= WResp;
                        bvalid_q <= 1'b1;
                        bresp_q  <= (werr_q || perr_q) ? 2'b10 : 2'b00;
                    end else begin
                        wcnt_q <= wcnt_q + 8'd1;
                    end
                end
                WResp: begin
                    if (bus.bready) begin
                        wstate_q  <= WIdle;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                    end
                end
                default: wstate_q <= WIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && w_fire && !werr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.wstrb[i]) begin
                    mem[waddr_q][8*i +: 8] <= bus.wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.awready = awready_q;
    assign bus.wready  = wready_q;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: directed vector table, multi-cycle corner
// sequences and randomized bursts against an array-based memory model.
module tb_axi_sram_slave;

    localparam int Depth = 4096;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    axi_sram_slave_if bus ();

    axi_sram_slave #(
        .ADDR_W   (12),
        .READ_LAT (2),
        .WRITE_LAT(1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int    n_checks = 0;
    int    n_pass   = 0;
    string ctx      = "init";

    logic [31:0] model_mem [Depth];

    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    int          rd_n;
    int          rd_lat;

    typedef struct {
        bit          wr;
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [31:0] data;
        logic [31:0] step;
        logic [3:0]  strb;
        int          bad;
        logic [1:0]  exp_resp;
        logic [31:0] exp_d0;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s/%s: got %h, expected %h", ctx, name, act, exp);
    endtask

    function automatic bit addr_err(input logic [31:0] a);
        return (a >> 14) != 0;
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [31:0] data0, input logic [31:0] step,
                            input logic [3:0] strb, input int bad,
                            output logic [3:0] got_bid, output logic [1:0] got_bresp,
                            output int lat);
        int guard;
        bit ok;
        logic [31:0] d;
        int w;
        bus.awid = id; bus.awaddr = addr; bus.awlen = len; bus.awvalid = 1'b1;
        guard = 0;
        do begin ok = bus.awready; @(negedge clk); guard++; end while (!ok && guard < 50);
        bus.awvalid = 1'b0;
        check("aw_handshake", 32'(ok), 32'd1);
        for (int i = 0; i <= int'(len); i++) begin
            d = data0 + 32'(i) * step;
            bus.wdata = d; bus.wstrb = strb;
            bus.wlast = (i == int'(len)) ^ (i == bad);
            bus.wvalid = 1'b1;
            guard = 0;
            do begin ok = bus.wready; @(negedge clk); guard++; end while (!ok && guard < 50);
            if (!ok) check("w_handshake", 32'(ok), 32'd1);
            if (ok && !addr_err(addr)) begin
                w = (word_of(addr) + i) % Depth;
                for (int b = 0; b < 4; b++) if (strb[b]) model_mem[w][8*b +: 8] = d[8*b +: 8];
            end
        end
        bus.wvalid = 1'b0; bus.wlast = 1'b0;
        lat = 1;
        while (!bus.bvalid && lat < 50) begin @(negedge clk); lat++; end
        got_bid = bus.bid; got_bresp = bus.bresp;
        bus.bready = 1'b1;
        @(negedge clk);
        bus.bready = 1'b0;
        check("awready_after_b", 32'(bus.awready), 32'd1);
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [31:0] pat, input int patlen);
        int guard, k;
        bit ok, stalled, rr;
        logic [31:0] prev_data;
        logic prev_last;
        bus.arid = id; bus.araddr = addr; bus.arlen = len; bus.arvalid = 1'b1;
        guard = 0;
        do begin ok = bus.arready; @(negedge clk); guard++; end while (!ok && guard < 50);
        bus.arvalid = 1'b0;
        check("ar_handshake", 32'(ok), 32'd1);
        rd_lat = 1;
        while (!bus.rvalid && rd_lat < 50) begin @(negedge clk); rd_lat++; end
        rd_n = 0; k = 0; guard = 0; stalled = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        while (rd_n <= int'(len) && guard < 400) begin
            if (bus.rvalid) begin
                if (stalled) begin
                    check("r_hold_data", bus.rdata, prev_data);
                    check("r_hold_last", 32'(bus.rlast), 32'(prev_last));
                end
                rr = pat[k % patlen];
                k++;
                bus.rready = rr;
                if (rr) begin
                    rd_data[rd_n] = bus.rdata; rd_resp[rd_n] = bus.rresp;
                    rd_last[rd_n] = bus.rlast; rd_id[rd_n] = bus.rid;
                    rd_n++;
                end
                prev_data = bus.rdata; prev_last = bus.rlast; stalled = !rr;
            end else begin
                bus.rready = 1'b0;
            end
            @(negedge clk);
            guard++;
        end
        bus.rready = 1'b0;
        check("r_beats", 32'(rd_n), 32'(int'(len) + 1));
        check("rvalid_after_burst", 32'(bus.rvalid), 32'd0);
        check("arready_after_burst", 32'(bus.arready), 32'd1);
    endtask

    task automatic check_read_model(input logic [3:0] id, input logic [31:0] addr,
                                    input logic [3:0] len);
        bit err;
        err = addr_err(addr);
        check("r_latency", 32'(rd_lat), 32'd3);
        for (int i = 0; i < rd_n; i++) begin
            check("rdata", rd_data[i], err ? 32'h0 : model_mem[(word_of(addr) + i) % Depth]);
            check("rresp", 32'(rd_resp[i]), err ? 32'd2 : 32'd0);
            check("rlast", 32'(rd_last[i]), 32'(i == int'(len)));
            check("rid", 32'(rd_id[i]), 32'(id));
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0]  got_bid;
        logic [1:0]  got_bresp;
        int          lat;
        int          guard;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [3:0]  strb;
        int          off, lmax, bad;

        reset = 1'b1;
        bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
        repeat (3) @(negedge clk);

        ctx = "reset";
        check("arready", 32'(bus.arready), 32'd1);
        check("awready", 32'(bus.awready), 32'd1);
        check("rvalid",  32'(bus.rvalid),  32'd0);
        check("rlast",   32'(bus.rlast),   32'd0);
        check("wready",  32'(bus.wready),  32'd0);
        check("bvalid",  32'(bus.bvalid),  32'd0);
        check("rid_bid", {24'h0, bus.rid, bus.bid}, 32'h0);
        check("resps",   {28'h0, bus.rresp, bus.bresp}, 32'h0);
        check("rdata",   bus.rdata, 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Populate the random-phase window (words 4080..4095 and 0..15).
        ctx = "fill";
        do_write(4'd0, 32'(4080 * 4), 4'd15, $urandom, $urandom, 4'hF, -1, got_bid, got_bresp, lat);
        do_write(4'd0, 32'h0, 4'd15, $urandom, $urandom, 4'hF, -1, got_bid, got_bresp, lat);

        //        wr    id     addr         len    data          step   strb  bad exp_resp exp_d0
        vecs[0]  = '{1'b1, 4'd3, 32'h10,     4'd0, 32'hDEADBEEF, 32'd0, 4'hF, -1, 2'b00, 32'h0};
        vecs[1]  = '{1'b0, 4'd5, 32'h10,     4'd0, 32'h0,        32'd0, 4'h0, -1, 2'b00, 32'hDEADBEEF};
        vecs[2]  = '{1'b1, 4'd1, 32'h100,    4'd3, 32'd1,        32'd1, 4'hF, -1, 2'b00, 32'h0};
        vecs[3]  = '{1'b1, 4'd2, 32'h20,     4'd0, 32'hFFFFFFFF, 32'd0, 4'hF, -1, 2'b00, 32'h0};
        vecs[4]  = '{1'b1, 4'd4, 32'h20,     4'd0, 32'h11223344, 32'd0, 4'h5, -1, 2'b00, 32'h0};
        vecs[5]  = '{1'b0, 4'd6, 32'h20,     4'd0, 32'h0,        32'd0, 4'h0, -1, 2'b00, 32'hFF22FF44};
        vecs[6]  = '{1'b1, 4'd7, 32'h0,      4'd0, 32'hA5A5A5A5, 32'd0, 4'hF, -1, 2'b00, 32'h0};
        vecs[7]  = '{1'b0, 4'd8, 32'h4000,   4'd1, 32'h0,        32'd0, 4'h0, -1, 2'b10, 32'h0};
        vecs[8]  = '{1'b1, 4'd9, 32'h4000,   4'd0, 32'h12345678, 32'd0, 4'hF, -1, 2'b10, 32'h0};
        vecs[9]  = '{1'b0, 4'hA, 32'h0,      4'd0, 32'h0,        32'd0, 4'h0, -1, 2'b00, 32'hA5A5A5A5};
        vecs[10] = '{1'b1, 4'hB, 32'h200,    4'd2, 32'h50,       32'd1, 4'hF, 0,  2'b10, 32'h0};
        vecs[11] = '{1'b0, 4'hC, 32'h200,    4'd2, 32'h0,        32'd0, 4'h0, -1, 2'b00, 32'h50};

        for (int v = 0; v < 12; v++) begin
            ctx = $sformatf("vec%0d", v);
            if (vecs[v].wr) begin
                do_write(vecs[v].id, vecs[v].addr, vecs[v].len, vecs[v].data, vecs[v].step,
                         vecs[v].strb, vecs[v].bad, got_bid, got_bresp, lat);
                check("b_latency", 32'(lat), 32'd2);
                check("bid", 32'(got_bid), 32'(vecs[v].id));
                check("bresp", 32'(got_bresp), 32'(vecs[v].exp_resp));
            end else begin
                do_read(vecs[v].id, vecs[v].addr, vecs[v].len, 32'hFFFFFFFF, 32);
                check("rdata0", rd_data[0], vecs[v].exp_d0);
                check("rresp0", 32'(rd_resp[0]), 32'(vecs[v].exp_resp));
                check_read_model(vecs[v].id, vecs[v].addr, vecs[v].len);
            end
        end

        // rready pattern 1,0,0,1,1,0,1 over the 4-beat burst at 0x100.
        ctx = "stall";
        do_read(4'd7, 32'h100, 4'd3, 32'h59, 7);
        for (int i = 0; i < 4; i++) begin
            check("stall_data", rd_data[i], 32'(i + 1));
            check("stall_last", 32'(rd_last[i]), 32'(i == 3));
        end

        // Reset while beat 2 of a 4-beat read is presented.
        ctx = "mid_reset";
        bus.arid = 4'd2; bus.araddr = 32'h100; bus.arlen = 4'd3; bus.arvalid = 1'b1;
        guard = 0;
        while (!bus.arready && guard < 50) begin @(negedge clk); guard++; end
        @(negedge clk);
        bus.arvalid = 1'b0;
        guard = 0;
        while (!bus.rvalid && guard < 50) begin @(negedge clk); guard++; end
        bus.rready = 1'b1;
        repeat (2) @(negedge clk);
        bus.rready = 1'b0;
        check("beat2_data", bus.rdata, 32'd3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rvalid", 32'(bus.rvalid), 32'd0);
        check("rlast", 32'(bus.rlast), 32'd0);
        check("arready", 32'(bus.arready), 32'd1);
        bus.rready = 1'b1;
        repeat (6) @(negedge clk);
        bus.rready = 1'b0;
        check("no_stray_beat", 32'(bus.rvalid), 32'd0);
        do_read(4'd9, 32'h100, 4'd3, 32'hFFFFFFFF, 32);
        check_read_model(4'd9, 32'h100, 4'd3);

        // Random bursts inside the filled window, including the address wrap at 4095->0.
        for (int n = 0; n < 40; n++) begin
            ctx = $sformatf("rand%0d", n);
            off  = $urandom_range(0, 31);
            lmax = (31 - off) < 15 ? (31 - off) : 15;
            len  = 4'($urandom_range(0, lmax));
            addr = 32'(((4080 + off) % Depth) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) addr = addr | (32'h1 << $urandom_range(14, 31));
            if ($urandom_range(0, 1) == 1) begin
                strb = 4'($urandom_range(0, 15));
                bad  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, int'(len)) : -1;
                do_write(4'($urandom), addr, len, $urandom, $urandom, strb, bad,
                         got_bid, got_bresp, lat);
                check("b_latency", 32'(lat), 32'd2);
                check("bresp", 32'(got_bresp), (addr_err(addr) || bad >= 0) ? 32'd2 : 32'd0);
            end else begin
                do_read(4'($urandom), addr, len, $urandom | 32'h1, 32);
                check_read_model(bus.arid, addr, len);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
